// File: rtl/word_tx.sv
// word_tx: accepts a DATA_WIDTH-bit word and streams it out LSB-first as bytes over a valid/ready link.
// Define WORD_TX_CHKSUM_EN to append an XOR checksum byte (state CHK) after the data bytes.
module word_tx #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_vld,
  output logic                  data_rdy,
  output logic [7:0]            tx_byte,
  output logic                  tx_vld,
  input  logic                  tx_rdy,
  output logic                  tx_last,
  output logic                  busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef WORD_TX_CHKSUM_EN
  // The checksum byte, not a data byte, carries tx_last.
  localparam logic LAST_ON_B0   = 1'b0;
  localparam logic LAST_ON_DATA = 1'b0;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CHK  = 2'd2
  } state_e;
`else
  localparam logic LAST_ON_B0   = (NUM_BYTES == 1);
  localparam logic LAST_ON_DATA = 1'b1;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] hold_q,  hold_d;
  logic [7:0]            byte_q,  byte_d;
  logic                  vld_q,   vld_d;
  logic                  last_q,  last_d;
  logic                  busy_q,  busy_d;
  logic                  rdy_q,   rdy_d;
`ifdef WORD_TX_CHKSUM_EN
  logic [7:0]            chk_q,   chk_d;
`endif
  logic                  accept_s;
  logic                  xfer_s;

  function automatic logic [7:0] byte_sel(input logic [DATA_WIDTH-1:0] word,
                                          input logic [CNT_W-1:0]      idx);
    byte_sel = 8'(word >> {idx, 3'b000});
  endfunction

  assign accept_s = data_vld && rdy_q;
  assign xfer_s   = vld_q && tx_rdy;

  // Next-state and next-output computation for the serializer FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    byte_d  = byte_q;
    vld_d   = vld_q;
    last_d  = last_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
`ifdef WORD_TX_CHKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SEND;
          hold_d  = data_in;
          cnt_d   = '0;
          byte_d  = data_in[7:0];
          vld_d   = 1'b1;
          last_d  = LAST_ON_B0;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
`ifdef WORD_TX_CHKSUM_EN
          chk_d   = 8'h00;
`endif
        end else begin
          vld_d  = 1'b0;
          last_d = 1'b0;
          busy_d = 1'b0;
          rdy_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (xfer_s && (cnt_q == LAST_IDX)) begin
          cnt_d = '0;
`ifdef WORD_TX_CHKSUM_EN
          state_d = ST_CHK;
          byte_d  = chk_q ^ byte_q;
          chk_d   = chk_q ^ byte_q;
          last_d  = 1'b1;
`else
          state_d = ST_IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
`endif
        end else if (xfer_s) begin
          cnt_d  = cnt_q + CNT_ONE;
          byte_d = byte_sel(hold_q, cnt_q + CNT_ONE);
          last_d = LAST_ON_DATA && ((cnt_q + CNT_ONE) == LAST_IDX);
`ifdef WORD_TX_CHKSUM_EN
          chk_d  = chk_q ^ byte_q;
`endif
        end else begin
          state_d = ST_SEND;
        end
      end
`ifdef WORD_TX_CHKSUM_EN
      ST_CHK: begin
        if (xfer_s) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
        end else begin
          state_d = ST_CHK;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef WORD_TX_CHKSUM_EN
      chk_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
`ifdef WORD_TX_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign data_rdy = rdy_q;
  assign tx_byte  = byte_q;
  assign tx_vld   = vld_q;
  assign tx_last  = last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_word_tx.sv
// Self-checking bench for word_tx (DATA_WIDTH=32): vector table, directed corner sequences,
// and randomized traffic checked cycle by cycle against a byte-queue reference model.
module tb_word_tx;

`ifdef WORD_TX_CHKSUM_EN
  localparam int NB_TOT = 5;
  localparam bit CHK_EN = 1'b1;
`else
  localparam int NB_TOT = 4;
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [31:0] data_in;
  logic        data_vld;
  logic        data_rdy;
  logic [7:0]  tx_byte;
  logic        tx_vld;
  logic        tx_rdy;
  logic        tx_last;
  logic        busy;

  word_tx #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .data_in  (data_in),
    .data_vld (data_vld),
    .data_rdy (data_rdy),
    .tx_byte  (tx_byte),
    .tx_vld   (tx_vld),
    .tx_rdy   (tx_rdy),
    .tx_last  (tx_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } item_t;

  typedef struct {
    logic [31:0]     word;
    logic [4:0][7:0] bytes;   // bytes[4] is the checksum
  } vec_t;

  item_t mq[$];
  logic  m_rdy = 1'b0;
  logic  m_rst = 1'b0;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    item_t      it;
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 4; k++) begin
      it.b    = w[8*k +: 8];
      it.last = (k == 3) && !CHK_EN;
      x       = x ^ it.b;
      mq.push_back(it);
    end
    if (CHK_EN) begin
      it.b    = x;
      it.last = 1'b1;
      mq.push_back(it);
    end
  endtask

  // One clock: advance the reference model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      mq.delete();
      m_rdy = 1'b0;
      m_rst = 1'b1;
    end else begin
      if (mq.size() != 0) begin
        if (tx_rdy) mq.delete(0);
      end else if (m_rdy && data_vld) begin
        push_word(data_in);
      end
      m_rdy = (mq.size() == 0);
      m_rst = 1'b0;
    end
    #1;
    check("m_data_rdy", 32'(data_rdy), 32'(m_rdy));
    check("m_busy", 32'(busy), 32'(mq.size() != 0));
    check("m_tx_vld", 32'(tx_vld), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("m_tx_byte", 32'(tx_byte), 32'(mq[0].b));
      check("m_tx_last", 32'(tx_last), 32'(mq[0].last));
    end else if (m_rst) begin
      check("rst_tx_byte", 32'(tx_byte), 32'h0);
      check("rst_tx_last", 32'(tx_last), 32'h0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n        = 0;
    rstn     = 1'b1;
    data_vld = 1'b0;
    tx_rdy   = 1'b1;
    while (!m_rdy && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!m_rdy) begin
      errors++;
      $display("FAIL wait_idle: block never returned to idle within %0d cycles", n);
    end
  endtask

  vec_t       tab [0:6];
  logic [7:0] exp34 [0:9];
  logic [7:0] obs_b [0:15];
  int         obs_c [0:15];
  int         obs_n;

  initial begin
    tab[0].word = 32'h44332211; tab[0].bytes = {8'h44, 8'h44, 8'h33, 8'h22, 8'h11};
    tab[1].word = 32'h01020304; tab[1].bytes = {8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    tab[2].word = 32'hA0B0C0D0; tab[2].bytes = {8'h00, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    tab[3].word = 32'hDEADBEEF; tab[3].bytes = {8'h22, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tab[4].word = 32'hCAFEF00D; tab[4].bytes = {8'hC9, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    tab[5].word = 32'h00000000; tab[5].bytes = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tab[6].word = 32'hFFFFFFFF; tab[6].bytes = {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    if (CHK_EN) begin
      exp34[0] = 8'h04; exp34[1] = 8'h03; exp34[2] = 8'h02; exp34[3] = 8'h01; exp34[4] = 8'h04;
      exp34[5] = 8'hD0; exp34[6] = 8'hC0; exp34[7] = 8'hB0; exp34[8] = 8'hA0; exp34[9] = 8'h00;
    end else begin
      exp34[0] = 8'h04; exp34[1] = 8'h03; exp34[2] = 8'h02; exp34[3] = 8'h01;
      exp34[4] = 8'hD0; exp34[5] = 8'hC0; exp34[6] = 8'hB0; exp34[7] = 8'hA0;
      exp34[8] = 8'h00; exp34[9] = 8'h00;
    end

    // Reset state.
    rstn = 1'b0; data_vld = 1'b0; data_in = 32'h0; tx_rdy = 1'b0;
    step();
    step();
    check("reset_rdy", 32'(data_rdy), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_byte", 32'(tx_byte), 32'h0);
    rstn = 1'b1;
    step();
    check("first_rdy", 32'(data_rdy), 32'h1);

    // Vector table: each word with tx_rdy=1, byte k expected on cycle +1+k.
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      data_in  = tab[i].word;
      data_vld = 1'b1;
      step();
      data_vld = 1'b0;
      data_in  = $urandom;
      for (int k = 0; k < NB_TOT; k++) begin
        check("tab_vld", 32'(tx_vld), 32'h1);
        check("tab_byte", 32'(tx_byte), 32'(tab[i].bytes[k]));
        check("tab_last", 32'(tx_last), 32'(k == NB_TOT - 1));
        step();
      end
      check("tab_done_rdy", 32'(data_rdy), 32'h1);
      check("tab_done_vld", 32'(tx_vld), 32'h0);
      check("tab_done_last", 32'(tx_last), 32'h0);
    end

    // Backpressure while 0x22 is presented.
    wait_idle();
    data_in = 32'h44332211; data_vld = 1'b1;
    step();
    data_vld = 1'b0;
    check("bp_b0", 32'(tx_byte), 32'h11);
    step();
    check("bp_b1", 32'(tx_byte), 32'h22);
    tx_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_byte", 32'(tx_byte), 32'h22);
      check("bp_hold_vld", 32'(tx_vld), 32'h1);
    end
    tx_rdy = 1'b1;
    step();
    check("bp_b2", 32'(tx_byte), 32'h33);

    // data_vld held while busy: ignored until the first idle cycle.
    wait_idle();
    data_in = 32'h55667788; data_vld = 1'b1;
    step();
    data_in = 32'hCAFEF00D;
    for (int k = 0; k < NB_TOT; k++) begin
      check("held_rdy_low", 32'(data_rdy), 32'h0);
      step();
    end
    check("held_rdy_high", 32'(data_rdy), 32'h1);
    step();
    data_vld = 1'b0;
    check("held_b0", 32'(tx_byte), 32'h0D);
    check("held_vld", 32'(tx_vld), 32'h1);

    // Reset mid-word after 0x22 transfers.
    wait_idle();
    data_in = 32'h44332211; data_vld = 1'b1;
    step();
    data_vld = 1'b0;
    step();
    step();
    rstn = 1'b0;
    step();
    check("midrst_vld", 32'(tx_vld), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    step();
    check("midrst_rdy", 32'(data_rdy), 32'h1);
    check("midrst_vld2", 32'(tx_vld), 32'h0);
    data_in = 32'hDEADBEEF; data_vld = 1'b1;
    step();
    data_vld = 1'b0;
    check("midrst_next_b0", 32'(tx_byte), 32'hEF);

    // Back-to-back words with data_vld and tx_rdy held high.
    wait_idle();
    data_in = 32'h01020304; data_vld = 1'b1;
    step();
    data_in = 32'hA0B0C0D0;
    obs_n = 0;
    for (int c = 0; c < 2 * NB_TOT + 1; c++) begin
      if (tx_vld && obs_n < 16) begin
        obs_b[obs_n] = tx_byte;
        obs_c[obs_n] = cyc;
        obs_n++;
      end
      step();
    end
    data_vld = 1'b0;
    check("b2b_count", 32'(obs_n), 32'(2 * NB_TOT));
    for (int j = 0; j < 2 * NB_TOT; j++) check("b2b_byte", 32'(obs_b[j]), 32'(exp34[j]));
    check("b2b_period", 32'(obs_c[NB_TOT] - obs_c[0]), 32'(NB_TOT + 1));

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rstn     = ($urandom_range(0, 99) != 0);
      data_vld = 1'($urandom_range(0, 1));
      data_in  = $urandom;
      tx_rdy   = ($urandom_range(0, 3) != 0);
      step();
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_tx.md
WORD_TX -- requirements
Module: word_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the parallel input word; legal values are multiples of 8 and at least 8; NUM_BYTES = DATA_WIDTH/8.
REQ-002 SHALL have port clk  input  1  the clock; all logic is on the rising edge.
REQ-003 SHALL have port rstn  input  1  the reset: synchronous, active-low.
REQ-004 SHALL have port data_in  input  DATA_WIDTH  the parallel word to transmit.
REQ-005 SHALL have port data_vld  input  1  asserted when data_in holds a word to send.
REQ-006 SHALL have port data_rdy  output  1  asserted when the block can accept a word.
REQ-007 SHALL have port tx_byte  output  8  the current output byte.
REQ-008 SHALL have port tx_vld  output  1  asserted when tx_byte is valid.
REQ-009 SHALL have port tx_rdy  input  1  downstream accepts tx_byte on this cycle.
REQ-010 SHALL have port tx_last  output  1  marks the final byte of the current word.
REQ-011 SHALL have port busy  output  1  asserted while a word is in transmission.

Function
REQ-012 SHALL accept a word on a cycle with data_vld && data_rdy, registering data_in into an internal holding register.
REQ-013 SHALL drive data_rdy high only in state IDLE, decoded from registered state only (no combinational path from data_vld or tx_rdy).
REQ-014 SHALL implement FSM states IDLE, SEND and, with the configuration macro only, CHK. Transitions: IDLE->SEND on accept; SEND->IDLE on the final data-byte handshake (macro off); SEND->CHK on the final data-byte handshake (macro on); CHK->IDLE on the checksum handshake.
REQ-015 SHALL send bytes LSB-first: byte k = word[8k+7:8k], for k = 0..NUM_BYTES-1.
REQ-016 SHALL present byte 0 with tx_vld=1 on the cycle after the accept cycle; latency is one cycle.
REQ-017 SHALL count a byte transfer only on cycles with tx_vld && tx_rdy; the byte counter SHALL then advance by 1 and the next byte SHALL appear on the following cycle.
REQ-018 SHALL hold tx_byte, tx_vld and tx_last stable while tx_vld=1 and tx_rdy=0.
REQ-019 SHALL assert tx_last together with the final byte of the word: byte NUM_BYTES-1 with the macro off, or the checksum byte with the macro on.
REQ-020 SHALL drive tx_vld=0, tx_last=0, busy=0 and data_rdy=1 on the cycle after the final handshake.
REQ-021 SHALL give a minimum word period of NUM_BYTES+1 cycles (NUM_BYTES+2 with the macro) when tx_rdy and data_vld are held at 1.
REQ-022 SHALL ignore data_vld while data_rdy=0; the holding register SHALL NOT change during transmission.
REQ-023 SHALL drive busy=1 in SEND and CHK and busy=0 in IDLE.
REQ-024 SHALL keep tx_byte registered; it is don't-care when tx_vld=0 but SHALL read 0 after reset.

Reset
REQ-025 SHALL, on every cycle with rstn=0, set state=IDLE, byte counter=0, holding register=0, checksum=0, tx_byte=0x00, tx_vld=0, tx_last=0 and busy=0, and drive data_rdy=0.
REQ-026 SHALL drive data_rdy=1 on the first cycle with rstn=1.
REQ-027 SHALL, if reset arrives mid-word, abandon the word: no further bytes are sent after reset deasserts.

Configuration
REQ-028 SHALL, when macro WORD_TX_CHKSUM_EN is defined, keep an 8-bit running XOR of all data bytes sent and emit it as one extra byte in state CHK, with tx_last=1.
REQ-029 SHALL, when WORD_TX_CHKSUM_EN is undefined, omit state CHK and the checksum logic; exactly NUM_BYTES bytes are sent per word.

Verification (DATA_WIDTH=32)
REQ-030 SHALL cover: accept 0x44332211 with tx_rdy=1 -> bytes 0x11, 0x22, 0x33, 0x44 on cycles +1..+4, tx_last on 0x44; with the macro, a 5th byte 0x44 carries tx_last.
REQ-031 SHALL cover: tx_rdy=0 for 3 cycles while byte 0x22 is presented -> tx_byte stays 0x22 and tx_vld stays 1; 0x33 appears the cycle after tx_rdy returns to 1.
REQ-032 SHALL cover: data_vld=1 with data_in=0xCAFEF00D while busy -> not accepted (data_rdy=0); if data_vld is still held, the word is accepted on the first IDLE cycle and first byte 0x0D follows one cycle later.
REQ-033 SHALL cover: rstn=0 for 1 cycle after byte 0x22 transfers -> next cycle tx_vld=0 and busy=0; a subsequent word 0xDEADBEEF starts with byte 0xEF.
REQ-034 SHALL cover: back-to-back words 0x01020304 then 0xA0B0C0D0 with data_vld and tx_rdy held at 1 -> byte sequence 04 03 02 01 D0 C0 B0 A0, with a word period of 5 cycles (6 with the macro).
